// File: rtl/gravity_pkg.sv
// Shared definitions for the gravity frame sequencer: body indices, sweep
// length, the ordered-pair table and the sequencer state encoding.
package gravity_pkg;

   localparam logic [1:0] BODY_A = 2'd0;
   localparam logic [1:0] BODY_B = 2'd1;
   localparam logic [1:0] BODY_C = 2'd2;

   localparam int         NUM_STEPS = 12;
   localparam logic [3:0] LAST_STEP = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POS   = 2'd1,
      ST_SWEEP = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0] p;
      logic [1:0] q;
   } pair_t;

   // Each body is accelerated by the other two in turn.
   function automatic pair_t pair_lookup(input logic [2:0] pair);
      pair_t r;
      case (pair)
         3'd0:    r = '{p: BODY_A, q: BODY_B};
         3'd1:    r = '{p: BODY_A, q: BODY_C};
         3'd2:    r = '{p: BODY_B, q: BODY_A};
         3'd3:    r = '{p: BODY_B, q: BODY_C};
         3'd4:    r = '{p: BODY_C, q: BODY_A};
         3'd5:    r = '{p: BODY_C, q: BODY_B};
         default: r = '{p: BODY_A, q: BODY_B};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gravity_sequencer_frame_gate.sv
// Decides which frame ticks run physics: frame divider while running,
// one-shot arming via single_step while paused.
module frame_gate #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             pause,
   input  logic             single_step,
   input  logic             restart,
   input  logic [DIV_W-1:0] frame_div,
   output logic             run_frame
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             div_hit;

   assign div_hit = (cnt_q == frame_div);

   always_comb begin
      run_frame = 1'b0;
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      if (restart) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else begin
         if (frame_tick) begin
            if (pause) begin
               run_frame = armed_q;
               armed_d   = 1'b0;
            end else begin
               run_frame = div_hit;
               cnt_d     = div_hit ? '0 : cnt_q + 1'b1;
            end
         end
         // An arm request in the same cycle as a paused tick survives for the next tick.
         if (single_step && pause) begin
            armed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/gravity_sequencer.sv
// Frame scheduler: position-update strobe per physics frame, then a 12-step
// velocity sweep handed to the gravity ALU over valid/ready during blanking.
module gravity_sequencer
   import gravity_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             blanking,
   input  logic             pause,
   input  logic             single_step,
   input  logic             restart,
   input  logic [DIV_W-1:0] frame_div,
   input  logic             clear_overrun,
   output logic             load_init,
   output logic             pos_update,
   output logic             step_valid,
   input  logic             step_ready,
   output logic [1:0]       p_idx,
   output logic [1:0]       q_idx,
   output logic             axis,
   output logic             busy,
   output logic             overrun
);

   state_t     state_q, state_d;
   logic [3:0] k_q, k_d;
   logic       step_valid_q, step_valid_d;
   logic [1:0] p_q, p_d;
   logic [1:0] q_q, q_d;
   logic       axis_q, axis_d;
   logic       pos_update_q, pos_update_d;
   logic       load_init_q, load_init_d;
   logic       overrun_q, overrun_d;

   logic       run_frame;
   logic       handshake;
   logic       sweep_done;
   logic       set_overrun;
   logic       issue;
   logic [3:0] issue_k;
   logic [3:0] k_after;
   pair_t      issue_pair;

   frame_gate #(.DIV_W(DIV_W)) u_frame_gate (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .pause       (pause),
      .single_step (single_step),
      .restart     (restart),
      .frame_div   (frame_div),
      .run_frame   (run_frame)
   );

   assign handshake  = step_valid_q && step_ready;
   assign sweep_done = handshake && (k_q == LAST_STEP);
   assign k_after    = handshake ? k_q + 4'd1 : k_q;
   assign issue_pair = pair_lookup(issue_k[3:1]);

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      step_valid_d = step_valid_q;
      p_d          = p_q;
      q_d          = q_q;
      axis_d       = axis_q;
      pos_update_d = 1'b0;
      load_init_d  = 1'b0;
      set_overrun  = 1'b0;
      issue        = 1'b0;
      issue_k      = k_q;

      if (restart) begin
         load_init_d  = 1'b1;
         state_d      = ST_IDLE;
         step_valid_d = 1'b0;
         k_d          = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_frame) begin
                  state_d      = ST_POS;
                  pos_update_d = 1'b1;
               end
            end
            ST_POS: begin
               state_d = ST_SWEEP;
               k_d     = '0;
               issue   = blanking;
               issue_k = '0;
            end
            ST_SWEEP: begin
               if (run_frame) begin
                  // New physics frame preempts whatever is left of this sweep.
                  state_d      = ST_POS;
                  pos_update_d = 1'b1;
                  step_valid_d = 1'b0;
                  k_d          = '0;
                  set_overrun  = !sweep_done;
               end else if (sweep_done) begin
                  state_d      = ST_IDLE;
                  step_valid_d = 1'b0;
                  k_d          = '0;
               end else begin
                  k_d = k_after;
                  if (handshake || !step_valid_q) begin
                     step_valid_d = 1'b0;
                     issue        = blanking;
                     issue_k      = k_after;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Request fields are only reloaded when a fresh step is raised.
      if (issue) begin
         step_valid_d = 1'b1;
         p_d          = issue_pair.p;
         q_d          = issue_pair.q;
         axis_d       = issue_k[0];
      end

      if (set_overrun) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         step_valid_q <= 1'b0;
         p_q          <= '0;
         q_q          <= '0;
         axis_q       <= 1'b0;
         pos_update_q <= 1'b0;
         load_init_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         step_valid_q <= step_valid_d;
         p_q          <= p_d;
         q_q          <= q_d;
         axis_q       <= axis_d;
         pos_update_q <= pos_update_d;
         load_init_q  <= load_init_d;
         overrun_q    <= overrun_d;
      end
   end

   assign load_init  = load_init_q;
   assign pos_update = pos_update_q;
   assign step_valid = step_valid_q;
   assign p_idx      = p_q;
   assign q_idx      = q_q;
   assign axis       = axis_q;
   assign busy       = (state_q != ST_IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_gravity_sequencer.sv
// Self-checking bench for gravity_sequencer: gating table, step scoreboard,
// and hand-written stall / overrun / restart sequences.
module tb_gravity_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick, blanking, pause, single_step, restart, clear_overrun;
   logic [3:0] frame_div;
   logic       load_init, pos_update, step_valid, step_ready;
   logic [1:0] p_idx, q_idx;
   logic       axis, busy, overrun;

   always #5 clk = ~clk;

   gravity_sequencer #(.DIV_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .blanking      (blanking),
      .pause         (pause),
      .single_step   (single_step),
      .restart       (restart),
      .frame_div     (frame_div),
      .clear_overrun (clear_overrun),
      .load_init     (load_init),
      .pos_update    (pos_update),
      .step_valid    (step_valid),
      .step_ready    (step_ready),
      .p_idx         (p_idx),
      .q_idx         (q_idx),
      .axis          (axis),
      .busy          (busy),
      .overrun       (overrun)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] p;
      logic [1:0] q;
      logic       ax;
   } step_t;
   step_t exp_q[$];
   step_t mon_s;

   typedef struct {
      int div;
      bit pause;
      bit sstep;
      bit exp_pos;
   } vec_t;
   vec_t tbl[16];

   logic [1:0] pair_p[6];
   logic [1:0] pair_q[6];

   logic       prev_valid, prev_ready, prev_tick, prev_restart, prev_blank, prev_reset;
   logic [1:0] prev_p, prev_q;
   logic       prev_ax;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame();
      for (int k = 0; k < 12; k++) begin
         step_t s;
         s.p  = pair_p[k / 2];
         s.q  = pair_q[k / 2];
         s.ax = (k % 2) == 1;
         exp_q.push_back(s);
      end
   endtask

   // One-cycle frame_tick; returns in the cycle right after it was sampled.
   task automatic do_tick(input bit run);
      @(posedge clk); #1;
      frame_tick = 1'b1;
      if (run) push_frame();
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!step_valid && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid_timeout", step_valid, 1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_timeout", busy, 0);
   endtask

   // Handshake scoreboard plus hold / blanking-rise protocol monitors.
   always @(negedge clk) begin
      if (!reset) begin
         if (step_valid && step_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL step_unexpected: got p=%0d q=%0d axis=%0d expected no step", p_idx, q_idx, axis);
            end else begin
               mon_s = exp_q.pop_front();
               check("step_p", p_idx, mon_s.p);
               check("step_q", q_idx, mon_s.q);
               check("step_axis", axis, mon_s.ax);
            end
         end
         if (!prev_reset && prev_valid && !prev_ready && !prev_tick && !prev_restart) begin
            check("hold_valid", step_valid, 1);
            check("hold_p", p_idx, prev_p);
            check("hold_q", q_idx, prev_q);
            check("hold_axis", axis, prev_ax);
         end
         if (!prev_reset && step_valid && !prev_valid) begin
            check("rise_in_blanking", prev_blank, 1);
         end
      end
      prev_valid   <= step_valid;
      prev_ready   <= step_ready;
      prev_tick    <= frame_tick;
      prev_restart <= restart;
      prev_blank   <= blanking;
      prev_reset   <= reset;
      prev_p       <= p_idx;
      prev_q       <= q_idx;
      prev_ax      <= axis;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pair_p[0] = 2'd0; pair_q[0] = 2'd1;
      pair_p[1] = 2'd0; pair_q[1] = 2'd2;
      pair_p[2] = 2'd1; pair_q[2] = 2'd0;
      pair_p[3] = 2'd1; pair_q[3] = 2'd2;
      pair_p[4] = 2'd2; pair_q[4] = 2'd0;
      pair_p[5] = 2'd2; pair_q[5] = 2'd1;

      // divider 2: runs on 3rd and 6th tick
      tbl[0]  = '{2, 0, 0, 0};
      tbl[1]  = '{2, 0, 0, 0};
      tbl[2]  = '{2, 0, 0, 1};
      tbl[3]  = '{2, 0, 0, 0};
      tbl[4]  = '{2, 0, 0, 0};
      tbl[5]  = '{2, 0, 0, 1};
      // paused: idle until armed, armed runs once
      tbl[6]  = '{2, 1, 0, 0};
      tbl[7]  = '{2, 1, 0, 0};
      tbl[8]  = '{2, 1, 0, 0};
      tbl[9]  = '{2, 1, 1, 1};
      tbl[10] = '{2, 1, 0, 0};
      // divider 0 runs every frame; single_step ignored while unpaused
      tbl[11] = '{0, 0, 0, 1};
      tbl[12] = '{2, 0, 1, 0};
      tbl[13] = '{2, 1, 0, 0};
      tbl[14] = '{2, 0, 0, 0};
      tbl[15] = '{2, 0, 0, 1};

      reset = 1'b1;
      frame_tick = 0; blanking = 1; pause = 0; single_step = 0;
      restart = 0; clear_overrun = 0; frame_div = 4'd0; step_ready = 1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_step_valid", step_valid, 0);
      check("rst_pos_update", pos_update, 0);
      check("rst_load_init", load_init, 0);
      check("rst_overrun", overrun, 0);
      check("rst_p_idx", p_idx, 0);
      check("rst_q_idx", q_idx, 0);
      check("rst_axis", axis, 0);

      // full-rate sweep timing
      do_tick(1);
      @(negedge clk);
      check("t1_pos_update", pos_update, 1);
      check("t1_busy", busy, 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("step_valid_t%0d", i + 2), step_valid, 1);
         if (i == 0) check("pos_update_one_cycle", pos_update, 0);
      end
      @(negedge clk);
      check("t14_busy", busy, 0);
      check("t14_step_valid", step_valid, 0);
      check("t14_sb_empty", exp_q.size(), 0);

      for (int r = 0; r < 16; r++) begin
         frame_div = tbl[r].div[3:0];
         pause     = tbl[r].pause;
         if (tbl[r].sstep) begin
            @(posedge clk); #1 single_step = 1'b1;
            @(posedge clk); #1 single_step = 1'b0;
         end
         do_tick(tbl[r].exp_pos);
         @(negedge clk);
         check($sformatf("gate_row%0d", r), pos_update, tbl[r].exp_pos);
         wait_idle(40);
      end
      pause = 1'b0;
      frame_div = 4'd0;
      check("gate_sb_empty", exp_q.size(), 0);

      // slow ALU with blanking dropping mid-request
      step_ready = 1'b0;
      do_tick(1);
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         wait_valid(50);
         @(posedge clk); #1 blanking = (s % 2 == 0);
         @(posedge clk); #1;
         @(posedge clk); #1 step_ready = 1'b1;
         @(posedge clk); #1 step_ready = 1'b0;
         if (s % 2 == 1) begin
            @(negedge clk);
            check("no_rise_blank_low_a", step_valid, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("no_rise_blank_low_b", step_valid, 0);
            @(posedge clk); #1 blanking = 1'b1;
         end
      end
      @(negedge clk);
      wait_idle(20);
      check("slow_sb_empty", exp_q.size(), 0);

      // overrun: sweep stalled when the next running frame arrives
      do_tick(1);
      @(negedge clk);
      wait_valid(10);
      repeat (3) @(posedge clk);
      #1 frame_tick = 1'b1;
      exp_q.delete();
      push_frame();
      @(posedge clk); #1 frame_tick = 1'b0;
      @(negedge clk);
      check("ovr_pos_update", pos_update, 1);
      check("ovr_set", overrun, 1);
      check("ovr_valid_dropped", step_valid, 0);
      @(negedge clk);
      check("ovr_restart_valid", step_valid, 1);
      check("ovr_restart_p", p_idx, 0);
      check("ovr_restart_q", q_idx, 1);
      check("ovr_restart_axis", axis, 0);
      check("ovr_sticky", overrun, 1);
      @(posedge clk); #1 clear_overrun = 1'b1;
      @(posedge clk); #1 clear_overrun = 1'b0;
      @(negedge clk);
      check("ovr_cleared", overrun, 0);
      step_ready = 1'b1;
      wait_idle(30);
      check("ovr_sb_empty", exp_q.size(), 0);

      // tick coinciding with the final handshake: no overrun
      do_tick(1);
      repeat (12) @(posedge clk);
      #1 frame_tick = 1'b1;
      push_frame();
      @(posedge clk); #1 frame_tick = 1'b0;
      @(negedge clk);
      check("last_hs_pos_update", pos_update, 1);
      check("last_hs_no_overrun", overrun, 0);
      wait_idle(30);
      check("last_hs_sb_empty", exp_q.size(), 0);

      // restart together with a running tick mid-sweep
      step_ready = 1'b0;
      do_tick(1);
      @(negedge clk);
      wait_valid(10);
      @(posedge clk); #1;
      restart = 1'b1;
      frame_tick = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      restart = 1'b0;
      frame_tick = 1'b0;
      @(negedge clk);
      check("rs_load_init", load_init, 1);
      check("rs_no_pos_update", pos_update, 0);
      check("rs_busy", busy, 0);
      check("rs_step_valid", step_valid, 0);
      @(negedge clk);
      check("rs_load_init_one_cycle", load_init, 0);
      check("rs_stays_idle", busy, 0);
      step_ready = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gravity_sequencer.md
# gravity_sequencer

Frame-level scheduler for the three-body gravity datapath. It decides which frames run physics (pause, single-step, frame divider), issues the per-frame position-update strobe, and sequences the 12 velocity micro-steps (6 ordered planet pairs × 2 axes) to a shared, possibly multi-cycle gravity ALU through a valid/ready handshake. Micro-steps are issued only during VGA blanking. The block sits between the VGA timing generator and the gravity datapath in the top level.

## Interface
Parameters:
- `DIV_W`, 4: width of the frame-divider input and counter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse when the pixel position is (0,0).
- `blanking`  in  1  high outside the visible area.
- `pause`  in  1  level; while high, frames run no physics.
- `single_step`  in  1  pulse; while paused, arms exactly one physics frame.
- `restart`  in  1  pulse; requests a reload of initial state.
- `frame_div`  in  DIV_W  physics runs every `frame_div+1` frames.
- `clear_overrun`  in  1  pulse; clears `overrun`.
- `load_init`  out  1  one-cycle strobe: datapath reloads initial positions and velocities.
- `pos_update`  out  1  one-cycle strobe: datapath adds velocities to positions.
- `step_valid`  out  1  micro-step request.
- `step_ready`  in  1  datapath accepts or completes the step.
- `p_idx`  out  2  body being accelerated (0=A, 1=B, 2=C).
- `q_idx`  out  2  attractor body.
- `axis`  out  1  0=X, 1=Y.
- `busy`  out  1  high in POS and SWEEP.
- `overrun`  out  1  sticky: a sweep was cut short by `frame_tick`.

## Operation
- States: IDLE, POS, SWEEP.
- Reset values: state IDLE, all strobes 0, `step_valid` 0, `p_idx`/`q_idx`/`axis` 0, step counter 0, frame counter 0, armed 0, `overrun` 0.
- Frame gating on `frame_tick` in IDLE:
  - If `pause` is low: the frame counter increments. When counter == `frame_div`, the frame runs physics and the counter clears.
  - If `pause` is high: the frame runs physics only if armed, and armed then clears. The frame counter holds.
- `single_step` sets armed only while `pause` is high. It is ignored otherwise.
- Running frame:
  - IDLE→POS, with `pos_update` high for exactly one cycle.
  - POS→SWEEP next cycle, step counter = 0.
- Step counter k (0..11) decodes as pair = k>>1, `axis` = k[0].
- Pair order (p,q): 0=(0,1), 1=(0,2), 2=(1,0), 3=(1,2), 4=(2,0), 5=(2,1).
- Handshake rules:
  - `step_valid` may rise only in a cycle where `blanking` is high.
  - Once high, `step_valid` stays high, and `p_idx`/`q_idx`/`axis` stay stable, until a cycle with `step_valid && step_ready`, regardless of `blanking`.
  - On each handshake, k increments. The handshake at k=11 moves the state to IDLE with `step_valid` low the next cycle.
  - A new step can issue in the cycle after a handshake if `blanking` is high (maximum 1 step/cycle).
- `frame_tick` in SWEEP (running frame):
  - The outstanding step is dropped and `overrun` sets.
  - The state goes to POS; the new sweep starts at k=0.
  - A handshake completing in that same cycle still counts. If that handshake was k=11, the sweep is complete and no overrun is flagged.
- `frame_tick` in SWEEP (non-running frame): the sweep continues; only the gating counters update.
- `frame_tick` in POS cannot occur (one-cycle state).
- `restart`:
  - Next cycle `load_init` is high for one cycle.
  - State goes to IDLE, `step_valid` drops, k and the frame counter clear, armed clears.
  - `restart` has priority over `frame_tick` in the same cycle.
- Priority of `overrun` updates: a set wins over `clear_overrun` in the same cycle.
- Widths: k is 4 bits. The frame counter is `DIV_W` bits and compares for equality with `frame_div`. When `frame_div`=0, every frame runs.

## Timing
- `frame_tick` at cycle t (running frame) → `pos_update`=1 at t+1.
- First `step_valid` at t+2 at the earliest, if `blanking` is high at t+2.
- With `step_ready` tied high and continuous blanking: steps at t+2..t+13, `busy` low at t+14.
- `restart` at cycle t → `load_init`=1 at t+1.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `gravity_pkg`:
  - body index constants (A=0, B=1, C=2);
  - `NUM_STEPS`=12, `LAST_STEP`=11;
  - pair→(p,q) lookup function;
  - state enumeration.
- One sub-module, `frame_gate`: frame divider counter, pause/single-step arming logic, and the "run this frame" decision.

## Test plan
- Reset, `frame_div`=0, `pause`=0, `step_ready`=1, `blanking`=1, `frame_tick` at t → `pos_update` at t+1; steps (p,q,axis) = (0,1,0),(0,1,1),(0,2,0)…(2,1,1) at t+2..t+13; `busy` low at t+14.
- `step_ready` delayed 3 cycles per step, and `blanking` drops while `step_valid` is high → outputs held stable until ready. No new `step_valid` rises while `blanking` is low.
- `frame_div`=2, six `frame_tick`s → exactly two `pos_update` pulses, on the 3rd and 6th ticks.
- `pause`=1, three ticks → no activity. Then `single_step`, two more ticks → exactly one physics frame, on the first of those ticks.
- `step_ready`=0 held, second `frame_tick` → `overrun`=1, new `pos_update`, k restarts at 0. Then `clear_overrun` → `overrun`=0.
- `restart` asserted mid-sweep at the same cycle as `frame_tick` → `load_init` pulse, no `pos_update`, state IDLE, `step_valid`=0.
